l1d_down_lat_model: RTL and testbench
=====================================

# l1d_down_lat_model

Parametrised downstream latency emulator for the L1D miss path. It accepts miss requests carrying {req_id, mshr_id, way}, holds them in a DEPTH-entry buffer, and returns each one as a refill response after a per-request programmable latency. Responses go out either in acceptance order or out of order, lowest index first. It sits between the L1D MSHR refill request port and the refill return port, and replaces a fixed-latency downstream stub in block and subsystem benches.

## Interface
- DEPTH, 8: number of outstanding entries; power of two, 2..64.
- LAT_W, 8: width of the per-request latency field.
- OOO, 0: 0 = in-order return; 1 = out-of-order return.
- clk  in  1  single clock; all logic is rising-edge.
- rst  in  1  asynchronous, active-high reset.
- req_vld  in  1  request valid.
- req_rdy  out  1  request ready; equals (cnt != DEPTH).
- req_pld  in  pack_l1d_down_lat_pld  {req_id, mshr_id, way}.
- req_lat  in  LAT_W  cycles to hold this request before it becomes eligible.
- rsp_vld  out  1  response valid.
- rsp_rdy  in  1  response ready.
- rsp_pld  out  pack_l1d_down_lat_pld  payload of the presented entry.
- cnt  out  $clog2(DEPTH+1)  number of occupied entries.

## Operation
- **Per-entry state:**
  - vld bit, payload, LAT_W-bit countdown.
  - In-order mode only: an allocation-order FIFO of entry indices.
- **Accept:**
  - Fires on req_vld && req_rdy.
  - The lowest-index free entry is written with payload and countdown = req_lat.
  - In-order mode: the index is also pushed into the order FIFO.
- **Countdown:**
  - Each cycle, every valid entry with countdown > 0 decrements by 1.
  - It saturates at 0. An entry is eligible when valid and countdown == 0.
- **Selection, OOO=0:**
  - Candidate is the head of the order FIFO, and only if it is eligible.
  - Younger eligible entries wait.
- **Selection, OOO=1:**
  - Candidate is the lowest-index eligible entry.
- **Lock:**
  - Once rsp_vld is asserted, the selected index is latched in a lock register.
  - rsp_pld stays stable until rsp_vld && rsp_rdy, even if a lower-index entry becomes eligible.
- **Release:**
  - On the response handshake the entry is freed.
  - In-order mode: the order FIFO is popped.
  - The lock clears.
- **Simultaneous accept and release:**
  - Both take effect; cnt is unchanged.
  - A freed entry is not reusable in the same cycle. Allocation uses the pre-release free vector.
- **Full:**
  - cnt == DEPTH forces req_rdy = 0, even if a release fires that cycle.
- **Empty:**
  - rsp_vld = 0 and cnt = 0.
- **Reset:**
  - Reset in the middle of operation drops all entries and clears the order FIFO and lock.
  - Reset values: req_rdy = 1 (from cnt = 0), rsp_vld = 0, rsp_pld = 0, cnt = 0.
  - Outputs take these values asynchronously on rst assertion.

## Timing
- A request accepted at cycle T with req_lat = L is visible from T+1 with countdown L.
- It is eligible at T+1+L. L = 0 gives rsp_vld at T+1 at the earliest.
- rsp_vld / rsp_pld are combinational from registered state; there is no combinational path from req_* to rsp_*.
- req_rdy depends only on registered cnt; there is no path from rsp_rdy to req_rdy.
- Sustained throughput is one accept and one release per cycle.
- Back-pressure on rsp_rdy does not stop countdowns of other entries.
- cnt updates on the edge after a handshake: +1 per accept, -1 per release.

## Structure
- Shared package l1d_package gains:
  - typedef pack_l1d_down_lat_pld {req_id [REQ_ID_WIDHT], mshr_id [L1D_MSHR_ID_WIDTH], way [L1D_WAY_NUM]}.
  - Constant L1D_DOWN_LAT_DEPTH = 8.
- Sub-module l1d_down_lat_order_fifo:
  - DEPTH-entry FIFO of $clog2(DEPTH)-bit indices with push and pop.
  - Read and write pointers are one bit wider than the index for the full/empty decision.
  - Instantiated only when OOO == 0 (generate).
- Free-entry and eligible-entry selection are priority encoders inside the top module.

## Test plan
- **Single request:** OOO=0, one request {id=3, mshr=1, way=4'b0010}, L=5 at T, rsp_rdy=1 -> rsp_vld high only at T+6 with the same payload; cnt 1 from T+1 to T+6, 0 at T+7.
- **In-order return:** OOO=0, accept A (L=10) then B (L=0) -> B becomes eligible first but is returned only after A; response order A, B.
- **Out-of-order return:** OOO=1, same stimulus -> B returned at T+2, A at T+11.
- **Full and accept/release:**
  - Fill all 8 entries with L=0 and rsp_rdy=0 -> cnt=8, req_rdy=0, rsp_pld held at entry 0.
  - Raise rsp_rdy together with req_vld -> release fires, no accept that cycle.
  - Next cycle req_rdy=1 and the new request lands in entry 0.
- **Lock stability:** OOO=1, entry 5 eligible and presented with rsp_rdy=0; entry 1 becomes eligible -> rsp_pld stays entry 5 until its handshake, then entry 1 follows the next cycle.
- **Reset mid-operation:** assert rst with 4 entries pending and rsp_vld=1 -> rsp_vld=0, cnt=0, req_rdy=1 immediately; no stale response after deassert.

Source files
------------

// File: rtl/l1d_package.sv
// l1d_package: shared L1D types and constants.
package l1d_package;
    localparam int REQ_ID_WIDHT       = 8;
    localparam int L1D_MSHR_ID_WIDTH  = 4;
    localparam int L1D_WAY_NUM        = 4;
    localparam int L1D_DOWN_LAT_DEPTH = 8;

    typedef struct packed {
        logic [REQ_ID_WIDHT-1:0]      req_id;
        logic [L1D_MSHR_ID_WIDTH-1:0] mshr_id;
        logic [L1D_WAY_NUM-1:0]       way;
    } pack_l1d_down_lat_pld;
endpackage

// File: rtl/l1d_down_lat_order_fifo.sv
// l1d_down_lat_order_fifo: allocation-order FIFO of entry indices for in-order return.
module l1d_down_lat_order_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [$clog2(DEPTH)-1:0] push_idx,
    input  logic                     pop,
    output logic [$clog2(DEPTH)-1:0] head,
    output logic                     empty
);
    localparam int IW = $clog2(DEPTH);
    localparam int PW = IW + 1;

    logic [IW-1:0] mem [DEPTH];
    logic [PW-1:0] wp, rp;

    // the extra pointer bit separates full from empty; the parent's cnt guards overflow
    assign empty = wp == rp;
    assign head  = mem[rp[IW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (push) wp <= wp + PW'(1);
            if (pop) rp <= rp + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wp[IW-1:0]] <= push_idx;
    end
endmodule

// File: rtl/l1d_down_lat_model.sv
// l1d_down_lat_model: L1D miss-path downstream emulator returning each request after its own latency.
module l1d_down_lat_model
    import l1d_package::*;
#(
    parameter int DEPTH = L1D_DOWN_LAT_DEPTH,
    parameter int LAT_W = 8,
    parameter int OOO   = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         req_vld,
    output logic                         req_rdy,
    input  pack_l1d_down_lat_pld         req_pld,
    input  logic [LAT_W-1:0]             req_lat,
    output logic                         rsp_vld,
    input  logic                         rsp_rdy,
    output pack_l1d_down_lat_pld         rsp_pld,
    output logic [$clog2(DEPTH+1)-1:0]   cnt
);
    localparam int IW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [DEPTH-1:0]     vld, elig;
    pack_l1d_down_lat_pld pld [DEPTH];
    logic [LAT_W-1:0]     lat [DEPTH];
    logic [IW-1:0]        free_idx, cand_idx, lock_idx, sel;
    logic                 cand_vld, lock_vld, acc, rel;

    always_comb begin
        elig     = '0;
        free_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            elig[i] = vld[i] && lat[i] == '0;
            if (!vld[i]) free_idx = IW'(i);
        end
    end

    assign req_rdy = cnt != CW'(DEPTH);
    assign acc     = req_vld && req_rdy;
    assign sel     = lock_vld ? lock_idx : cand_idx;
    assign rsp_vld = lock_vld || cand_vld;
    assign rsp_pld = rsp_vld ? pld[sel] : '0;
    assign rel     = rsp_vld && rsp_rdy;

    generate
        if (OOO == 0) begin : g_ino
            logic fifo_empty;
            l1d_down_lat_order_fifo #(.DEPTH(DEPTH)) u_fifo (
                .clk      (clk),
                .rst      (rst),
                .push     (acc),
                .push_idx (free_idx),
                .pop      (rel),
                .head     (cand_idx),
                .empty    (fifo_empty)
            );
            assign cand_vld = !fifo_empty && elig[cand_idx];
        end else begin : g_ooo
            always_comb begin
                cand_idx = '0;
                cand_vld = 1'b0;
                for (int i = DEPTH - 1; i >= 0; i--) begin
                    if (elig[i]) begin
                        cand_idx = IW'(i);
                        cand_vld = 1'b1;
                    end
                end
            end
        end
    endgenerate

    // a presented but unaccepted response pins its index until the handshake
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld      <= '0;
            cnt      <= '0;
            lock_vld <= 1'b0;
            lock_idx <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pld[i] <= '0;
                lat[i] <= '0;
            end
        end else begin
            cnt      <= cnt + CW'(acc) - CW'(rel);
            lock_vld <= rsp_vld && !rsp_rdy;
            lock_idx <= sel;
            for (int i = 0; i < DEPTH; i++) begin
                if (acc && free_idx == IW'(i)) begin
                    vld[i] <= 1'b1;
                    pld[i] <= req_pld;
                    lat[i] <= req_lat;
                end else begin
                    if (rel && sel == IW'(i)) vld[i] <= 1'b0;
                    if (vld[i] && lat[i] != '0) lat[i] <= lat[i] - LAT_W'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_l1d_down_lat_model.sv
// tb_l1d_down_lat_model: random traffic into in-order and out-of-order instances, checked against a timestamp model.
module tb_l1d_down_lat_model;
    import l1d_package::*;

    localparam int DEPTH = 8;
    localparam int LAT_W = 8;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 req_vld, rsp_rdy;
    pack_l1d_down_lat_pld req_pld;
    logic [LAT_W-1:0]     req_lat;
    logic                 o_rdy [2];
    logic                 o_vld [2];
    pack_l1d_down_lat_pld o_pld [2];
    logic [3:0]           o_cnt [2];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        l1d_down_lat_model #(.DEPTH(DEPTH), .LAT_W(LAT_W), .OOO(g)) u_dut (
            .clk     (clk),
            .rst     (rst),
            .req_vld (req_vld),
            .req_rdy (o_rdy[g]),
            .req_pld (req_pld),
            .req_lat (req_lat),
            .rsp_vld (o_vld[g]),
            .rsp_rdy (rsp_rdy),
            .rsp_pld (o_pld[g]),
            .cnt     (o_cnt[g])
        );
    end

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // each entry remembers the cycle it becomes eligible and its acceptance sequence number
    bit                   mv [2][DEPTH];
    pack_l1d_down_lat_pld mp [2][DEPTH];
    int                   mr [2][DEPTH];
    int                   ms [2][DEPTH];
    bit                   lk [2];
    int                   li [2];
    int                   seq = 0;
    int                   cyc = 0;

    function automatic int pick(input int m);
        int best = -1;
        if (lk[m]) return li[m];
        for (int i = 0; i < DEPTH; i++) begin
            if (mv[m][i]) begin
                if (m == 0) begin
                    if (best < 0 || ms[m][i] < ms[m][best]) best = i;
                end else if (best < 0 && cyc >= mr[m][i]) best = i;
            end
        end
        if (m == 0 && best >= 0 && cyc < mr[m][best]) best = -1;
        return best;
    endfunction

    function automatic int occupied(input int m);
        int c = 0;
        for (int i = 0; i < DEPTH; i++) c += int'(mv[m][i]);
        return c;
    endfunction

    task automatic check_outputs();
        for (int m = 0; m < 2; m++) begin
            int p = pick(m);
            int c = occupied(m);
            chk($sformatf("cnt%0d", m), 32'(o_cnt[m]), c);
            chk($sformatf("req_rdy%0d", m), 32'(o_rdy[m]), 32'(c != DEPTH));
            chk($sformatf("rsp_vld%0d", m), 32'(o_vld[m]), 32'(p >= 0));
            if (p >= 0) chk($sformatf("rsp_pld%0d", m), 32'(o_pld[m]), 32'(mp[m][p]));
        end
    endtask

    task automatic step_model();
        for (int m = 0; m < 2; m++) begin
            int p = pick(m);
            int f = -1;
            for (int i = DEPTH - 1; i >= 0; i--) if (!mv[m][i]) f = i;
            if (p >= 0 && rsp_rdy) begin
                mv[m][p] = 1'b0;
                lk[m] = 1'b0;
            end else if (p >= 0) begin
                lk[m] = 1'b1;
                li[m] = p;
            end
            if (req_vld && occupied(m) + int'(p >= 0 && rsp_rdy) != DEPTH && f >= 0) begin
                mv[m][f] = 1'b1;
                mp[m][f] = req_pld;
                mr[m][f] = cyc + 1 + int'(req_lat);
                ms[m][f] = seq;
            end
        end
        seq++;
        cyc++;
    endtask

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            lk[m] = 1'b0;
            for (int i = 0; i < DEPTH; i++) mv[m][i] = 1'b0;
        end
    endtask

    task automatic drive(input int ph);
        int pv = ph == 0 ? 70 : ph == 1 ? 90 : 50;
        int pr = ph == 0 ? 20 : ph == 1 ? 90 : ph == 2 ? 50 : 30;
        req_vld = $urandom_range(0, 99) < pv;
        rsp_rdy = $urandom_range(0, 99) < pr;
        req_pld = 16'($urandom);
        req_lat = LAT_W'(ph == 2 ? $urandom_range(0, 20) : $urandom_range(0, 4));
    endtask

    initial begin
        rst = 1'b1;
        req_vld = 1'b0;
        rsp_rdy = 1'b0;
        req_pld = '0;
        req_lat = '0;
        model_reset();
        #1;
        for (int m = 0; m < 2; m++) begin
            chk($sformatf("rst_rdy%0d", m), 32'(o_rdy[m]), 1);
            chk($sformatf("rst_vld%0d", m), 32'(o_vld[m]), 0);
            chk($sformatf("rst_pld%0d", m), 32'(o_pld[m]), 0);
            chk($sformatf("rst_cnt%0d", m), 32'(o_cnt[m]), 0);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int ph = 0; ph < 4; ph++) begin
            for (int k = 0; k < 300; k++) begin
                check_outputs();
                drive(ph);
                step_model();
                @(negedge clk);
            end
        end
        for (int k = 0; k < 4; k++) begin
            check_outputs();
            req_vld = 1'b1;
            rsp_rdy = 1'b0;
            req_pld = 16'($urandom);
            req_lat = '0;
            step_model();
            @(negedge clk);
        end
        check_outputs();
        req_vld = 1'b0;
        #2 rst = 1'b1;
        #1;
        for (int m = 0; m < 2; m++) begin
            chk($sformatf("midrst_rdy%0d", m), 32'(o_rdy[m]), 1);
            chk($sformatf("midrst_vld%0d", m), 32'(o_vld[m]), 0);
            chk($sformatf("midrst_cnt%0d", m), 32'(o_cnt[m]), 0);
        end
        model_reset();
        cyc++;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 200; k++) begin
            check_outputs();
            drive(k < 20 ? 0 : 2);
            if (k < 3) req_vld = 1'b0;
            step_model();
            @(negedge clk);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
